// File: rtl/codec_init_sequencer.sv
// codec_init_sequencer: walks a fixed WM8731 register table through the I2C write engine
module codec_init_sequencer #(
  parameter logic [6:0] CHIP_ADDR      = 7'h1A,
  parameter int         GAP_CYCLES     = 4,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_finished,
  output logic        o_error,
  output logic [3:0]  o_cmd_idx,
  output logic        o_i2c_start,
  output logic [6:0]  o_i2c_addr,
  output logic        o_i2c_rw,
  output logic [15:0] o_i2c_reg_data,
  input  logic        i_i2c_finished
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, DONE} state_t;
  state_t        state;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  assign o_i2c_addr = CHIP_ADDR;
  assign o_i2c_rw   = 1'b0;
  // register/data word for the current entry, stable while idx is held
  always_comb begin
    o_i2c_reg_data = 16'h0097;
    case (o_cmd_idx)
      4'd1: o_i2c_reg_data = 16'h0297;
      4'd2: o_i2c_reg_data = 16'h0479;
      4'd3: o_i2c_reg_data = 16'h0679;
      4'd4: o_i2c_reg_data = 16'h0815;
      4'd5: o_i2c_reg_data = 16'h0A00;
      4'd6: o_i2c_reg_data = 16'h0C00;
      4'd7: o_i2c_reg_data = 16'h0E42;
      4'd8: o_i2c_reg_data = 16'h1019;
      4'd9: o_i2c_reg_data = 16'h1201;
      default: o_i2c_reg_data = 16'h0097;
    endcase
  end
  // sequencer FSM; finished/busy change on entry to DONE so the pulse fills the DONE cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_busy      <= 1'b0;
      o_finished  <= 1'b0;
      o_error     <= 1'b0;
      o_cmd_idx   <= '0;
      o_i2c_start <= 1'b0;
      tcnt        <= '0;
      gcnt        <= '0;
    end else begin
      o_i2c_start <= 1'b0;
      o_finished  <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          o_cmd_idx <= '0;
          o_error   <= 1'b0;
          o_busy    <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          o_i2c_start <= 1'b1;
          tcnt        <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (i_i2c_finished) begin
            if (o_cmd_idx == 4'd9) begin
              o_finished <= 1'b1;
              o_busy     <= 1'b0;
              state      <= DONE;
            end else if (GAP_CYCLES == 0) begin
              o_cmd_idx <= o_cmd_idx + 4'd1;
              state     <= ISSUE;
            end else begin
              gcnt  <= GW'(GAP_CYCLES - 1);
              state <= GAP;
            end
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            o_error    <= 1'b1;
            o_finished <= 1'b1;
            o_busy     <= 1'b0;
            state      <= DONE;
          end
        end
        GAP: if (gcnt == '0) begin
          o_cmd_idx <= o_cmd_idx + 4'd1;
          state     <= ISSUE;
        end else begin
          gcnt <= gcnt - 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_codec_init_sequencer.sv
// tb_codec_init_sequencer: directed checks of the codec init sequencer against an I2C engine model
module tb_codec_init_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start [2];
  logic        fin [2];
  logic        busy [2];
  logic        finished [2];
  logic        error [2];
  logic [3:0]  idx [2];
  logic        i2c_start [2];
  logic [6:0]  addr [2];
  logic        rw [2];
  logic [15:0] data [2];
  logic [15:0] tbl [10] = '{16'h0097, 16'h0297, 16'h0479, 16'h0679, 16'h0815,
                            16'h0A00, 16'h0C00, 16'h0E42, 16'h1019, 16'h1201};
  logic [15:0] words [2][10];
  logic [15:0] cur [2];
  int          tstart [2][10];
  int          tfin [2];
  int          nstart [2] = '{0, 0};
  int          nfin [2] = '{0, 0};
  int          cnt [2] = '{99, 99};
  bit          hold [2] = '{0, 0};
  logic        busy_at_fin [2];
  int          cyc = 0;
  int          withhold = -1;
  bit          spur = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  codec_init_sequencer #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .o_busy(busy[0]),
    .o_finished(finished[0]), .o_error(error[0]), .o_cmd_idx(idx[0]),
    .o_i2c_start(i2c_start[0]), .o_i2c_addr(addr[0]), .o_i2c_rw(rw[0]),
    .o_i2c_reg_data(data[0]), .i_i2c_finished(fin[0]));

  codec_init_sequencer #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(64)) dut_nogap (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .o_busy(busy[1]),
    .o_finished(finished[1]), .o_error(error[1]), .o_cmd_idx(idx[1]),
    .o_i2c_start(i2c_start[1]), .o_i2c_addr(addr[1]), .o_i2c_rw(rw[1]),
    .o_i2c_reg_data(data[1]), .i_i2c_finished(fin[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // engine model: finished 30 cycles after each start, optionally withheld or doubled during GAP
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        cnt[k] = 99;
        fin[k] = 1'b0;
        hold[k] = 0;
      end else begin
        if (i2c_start[k]) begin
          if (nstart[k] < 10) begin
            words[k][nstart[k]] = data[k];
            tstart[k][nstart[k]] = cyc;
          end
          nstart[k]++;
          cur[k] = data[k];
          cnt[k] = 0;
          hold[k] = (int'(idx[k]) == withhold);
        end else if (cnt[k] < 99) begin
          cnt[k]++;
        end
        fin[k] = !hold[k] && (cnt[k] == 30 || (spur && cnt[k] == 32));
        if (cnt[k] == 30 && !hold[k]) check("data_stable", data[k], cur[k]);
        if (finished[k]) begin
          nfin[k]++;
          tfin[k] = cyc;
          busy_at_fin[k] = busy[k];
        end
      end
    end
  end

  task automatic clear(input int k);
    nstart[k] = 0;
    nfin[k] = 0;
  endtask

  task automatic pulse(input int k);
    @(negedge clk);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic wait_fin(input int k, input int budget);
    int n = 0;
    while (nfin[k] < 1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("fin_seen", nfin[k], 1);
  endtask

  task automatic check_words(input int k);
    check("start_count", nstart[k], 10);
    for (int i = 0; i < 10; i++) check($sformatf("word%0d", i), words[k][i], tbl[i]);
  endtask

  initial begin
    int n;
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy[0], 0);
    check("rst_finished", finished[0], 0);
    check("rst_error", error[0], 0);
    check("rst_idx", idx[0], 0);
    check("rst_i2c_start", i2c_start[0], 0);
    check("rst_data", data[0], 16'h0097);
    check("addr", addr[0], 7'h1A);
    check("rw", rw[0], 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // full run with latency checks
    clear(0);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check("lat_busy_n1", busy[0], 1);
    check("lat_start_n1", i2c_start[0], 0);
    @(negedge clk);
    check("lat_start_n2", i2c_start[0], 1);
    check("lat_data", data[0], 16'h0097);
    @(negedge clk);
    check("lat_start_n3", i2c_start[0], 0);
    wait_fin(0, 600);
    check_words(0);
    for (int i = 0; i < 9; i++) check("spacing_gap4", tstart[0][i+1] - tstart[0][i], 36);
    check("fin_busy", busy_at_fin[0], 0);
    check("run1_error", error[0], 0);
    check("last_idx", idx[0], 9);
    repeat (40) @(negedge clk);
    check("single_fin", nfin[0], 1);
    // repeated start requests and a spurious finished during GAP
    clear(0);
    spur = 1;
    pulse(0);
    n = 0;
    while (nfin[0] < 1 && n < 600) begin
      @(negedge clk);
      start[0] = (n % 5 == 0) && nstart[0] < 10;
      n++;
    end
    start[0] = 1'b0;
    spur = 0;
    repeat (40) @(negedge clk);
    check_words(0);
    check("busy_window_fin", nfin[0], 1);
    // timeout on entry 3
    clear(0);
    withhold = 3;
    pulse(0);
    wait_fin(0, 400);
    check("to_error", error[0], 1);
    check("to_idx", idx[0], 3);
    check("to_starts", nstart[0], 4);
    check("to_latency", tfin[0] - tstart[0][3], 64);
    withhold = -1;
    repeat (3) @(negedge clk);
    check("to_error_sticky", error[0], 1);
    clear(0);
    pulse(0);
    check("rerun_error_clr", error[0], 0);
    check("rerun_busy", busy[0], 1);
    wait_fin(0, 600);
    check_words(0);
    check("rerun_error", error[0], 0);
    // zero-gap build
    clear(1);
    pulse(1);
    wait_fin(1, 600);
    check_words(1);
    for (int i = 0; i < 9; i++) check("spacing_gap0", tstart[1][i+1] - tstart[1][i], 32);
    check("nogap_error", error[1], 0);
    // asynchronous reset during WAIT of entry 5
    clear(0);
    pulse(0);
    n = 0;
    while (nstart[0] < 6 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("reach_idx5", nstart[0], 6);
    repeat (10) @(negedge clk);
    check("pre_rst_idx", idx[0], 5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy[0], 0);
    check("arst_idx", idx[0], 0);
    check("arst_i2c_start", i2c_start[0], 0);
    check("arst_error", error[0], 0);
    check("arst_finished", finished[0], 0);
    check("arst_data", data[0], 16'h0097);
    repeat (3) @(negedge clk);
    check("arst_no_fin", nfin[0], 0);
    rst_n = 1'b1;
    clear(0);
    pulse(0);
    wait_fin(0, 600);
    check_words(0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/codec_init_sequencer.md
Name: codec_init_sequencer

Overview:
Sequences the team's I2C write engine (module I2C) to program the WM8731 audio codec after power-up. It holds a fixed 10-entry table of 16-bit register/data words and issues one I2C write per entry, one after another. Each write is a single-cycle start pulse, then a wait for the engine's finished pulse, then a programmable idle gap. It sits between top-level reset/start logic and the I2C engine, and raises done/error status for the audio datapath.

Parameters:
CHIP_ADDR, 7'h1A, 7-bit codec slave address driven on o_i2c_addr
GAP_CYCLES, 4, idle cycles inserted after each finished pulse before the next start (0 allowed)
TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before aborting with error (must be >= 32)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  run request; sampled only in IDLE
o_busy  output  1  high from the cycle after an accepted i_start until the cycle that returns to IDLE
o_finished  output  1  one-cycle pulse when the sequence ends (success or abort)
o_error  output  1  sticky timeout flag; cleared by the next accepted i_start
o_cmd_idx  output  4  index of the current or last table entry (0..9)
o_i2c_start  output  1  one-cycle start pulse to the I2C engine
o_i2c_addr  output  7  constant CHIP_ADDR
o_i2c_rw  output  1  constant 0 (write)
o_i2c_reg_data  output  16  table[o_cmd_idx]; held stable from start pulse until finished is seen
i_i2c_finished  input  1  one-cycle done pulse from the I2C engine

Behaviour:
- Reset: asynchronous, active-low. i_rst_n is asynchronous, active-low; clock is i_clk. On reset, state=IDLE, o_busy=0, o_finished=0, o_error=0, o_cmd_idx=0, o_i2c_start=0, and the gap/timeout counters are 0. o_i2c_reg_data then shows table[0].
- Table (idx: word), fixed:
  - 0:0x0097, 1:0x0297, 2:0x0479, 3:0x0679, 4:0x0815
  - 5:0x0A00, 6:0x0C00, 7:0x0E42, 8:0x1019, 9:0x1201
- All outputs are registered, with one exception: o_i2c_reg_data is a combinational table lookup on the registered o_cmd_idx.
- States: IDLE, ISSUE, WAIT, GAP, DONE.
- IDLE:
  - If i_start=1: o_cmd_idx<=0, o_error<=0, go to ISSUE.
  - i_i2c_finished is ignored in IDLE.
- ISSUE (exactly 1 cycle):
  - o_i2c_start=1 registered, so it is high during the cycle after entry.
  - Timeout counter is cleared; go to WAIT.
  - Latency: i_start sampled at edge N, o_i2c_start high between edges N+1 and N+2.
- WAIT:
  - o_i2c_start=0 and the timeout counter increments.
  - On i_i2c_finished=1:
    - If o_cmd_idx==9, go to DONE.
    - Otherwise, if GAP_CYCLES==0, increment idx and go to ISSUE.
    - Otherwise, load the gap counter and go to GAP.
  - When the timeout counter reaches TIMEOUT_CYCLES-1 without finished: o_error<=1, go to DONE, idx frozen.
  - If finished and timeout occur in the same cycle, finished wins.
- GAP:
  - Counts GAP_CYCLES cycles.
  - On the last cycle: increment idx, go to ISSUE.
  - i_i2c_finished arriving here is ignored.
- DONE (1 cycle): o_finished=1 pulse, o_busy deasserts, go to IDLE.
- Busy window: i_start while busy, or in the DONE cycle, is ignored and does not queue.
- Re-run: a new i_start after return to IDLE replays the full table from idx 0.
- o_cmd_idx never exceeds 9; there is no wrap.
- Reset mid-operation: immediate return to reset values, no finished pulse. The I2C engine shares i_rst_n.
- o_i2c_reg_data must not change between the start pulse and the cycle finished is seen; idx changes only on the ISSUE entry path.

Test Plan:
- Reset, then i_start pulse with an engine model that returns finished 30 cycles after each start, GAP_CYCLES=4 -> 10 start pulses carrying 0x0097..0x1201 in table order. Consecutive starts are 30+1+4+1 cycles apart. One o_finished pulse follows; o_error=0 and o_busy drops with it.
- Latency check: i_start at edge N -> o_i2c_start high only between edges N+1 and N+2; o_busy high from N+1.
- Timeout: model withholds finished on idx 3, TIMEOUT_CYCLES=64 -> o_error=1 and o_finished pulse 64 cycles after the 4th start, o_cmd_idx=3. A later i_start clears o_error and restarts at 0x0097.
- i_start re-asserted repeatedly during the run, plus a spurious finished during GAP -> exactly 10 starts and one o_finished pulse.
- GAP_CYCLES=0 build -> next start issued 2 cycles after each finished; all 10 words are delivered.
- i_rst_n low during WAIT of idx 5 -> all outputs at reset values asynchronously and no o_finished. After release with i_start, the sequence restarts from idx 0.
